// File: rtl/note_seq_if.sv
// Bundle between note_seq and its neighbours: game-timer time, playback control, chart write port and note outputs.
// The master side is the game/control logic; the slave side is the sequencer.
interface note_seq_if #(
    parameter int NUM_TRACKS = 4,
    parameter int TIME_W     = 32,
    parameter int PITCH_W    = 32,
    parameter int IDX_W      = 7
);
    logic [TIME_W-1:0]     i_cur_time;
    logic                  i_start;
    logic                  i_pause;
    logic [IDX_W-1:0]      i_chart_len;
    logic                  i_wr_en;
    logic [IDX_W-1:0]      i_wr_addr;
    logic [TIME_W-1:0]     i_wr_time;
    logic [NUM_TRACKS-1:0] i_wr_mask;
    logic [PITCH_W-1:0]    i_wr_pitch;

    logic [NUM_TRACKS-1:0] o_note;
    logic                  o_note_valid;
    logic [IDX_W-1:0]      o_note_idx;
    logic [PITCH_W-1:0]    o_gen_pitch;
    logic                  o_busy;
    logic                  o_game_end;

    modport master (
        output i_cur_time, i_start, i_pause, i_chart_len,
        output i_wr_en, i_wr_addr, i_wr_time, i_wr_mask, i_wr_pitch,
        input  o_note, o_note_valid, o_note_idx, o_gen_pitch, o_busy, o_game_end
    );

    modport slave (
        input  i_cur_time, i_start, i_pause, i_chart_len,
        input  i_wr_en, i_wr_addr, i_wr_time, i_wr_mask, i_wr_pitch,
        output o_note, o_note_valid, o_note_idx, o_gen_pitch, o_busy, o_game_end
    );
endinterface

// File: rtl/note_seq.sv
// Chart sequencer: walks a loadable note chart and issues per-lane spawn pulses LEAD_MS ahead of each hit time.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for i_start after reset; chart writable
//   ST_RUN  | walking the chart, one note per cycle at most; chart locked
//   ST_DONE | every note issued, o_game_end high; chart writable, replay on i_start
module note_seq #(
    parameter int NUM_TRACKS = 4,
    parameter int NOTE_COUNT = 64,
    parameter int TIME_W     = 32,
    parameter int PITCH_W    = 32,
    parameter int LEAD_MS    = 0,
    parameter int IDX_W      = $clog2(NOTE_COUNT + 1)
) (
    input  logic     clk,
    input  logic     rst_n,
    note_seq_if.slave bus
);
    localparam int ADDR_W = (NOTE_COUNT > 1) ? $clog2(NOTE_COUNT) : 1;
    localparam logic [IDX_W-1:0] MAX_LEN  = IDX_W'(NOTE_COUNT);
    localparam logic [TIME_W:0]  LEAD_EXT = (TIME_W + 1)'(LEAD_MS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic             emit;

    logic [TIME_W-1:0]     time_mem  [NOTE_COUNT];
    logic [NUM_TRACKS-1:0] mask_mem  [NOTE_COUNT];
    logic [PITCH_W-1:0]    pitch_mem [NOTE_COUNT];

    logic              wr_ok;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [TIME_W:0]   lead_time;
    logic              due;
    logic [IDX_W-1:0]  len_in;

    // The chart is frozen while a run is walking it so a half-written chart is never played.
    assign wr_ok  = rst_n && bus.i_wr_en && (bus.i_wr_addr < MAX_LEN) && (state_q != ST_RUN);
    assign wr_idx = bus.i_wr_addr[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            time_mem[wr_idx]  <= bus.i_wr_time;
            mask_mem[wr_idx]  <= bus.i_wr_mask;
            pitch_mem[wr_idx] <= bus.i_wr_pitch;
        end
    end

    // One extra bit keeps cur_time + LEAD_MS from wrapping near the top of the time range.
    assign rd_idx    = idx_q[ADDR_W-1:0];
    assign lead_time = {1'b0, bus.i_cur_time} + LEAD_EXT;
    assign due       = lead_time >= {1'b0, time_mem[rd_idx]};
    assign len_in    = (bus.i_chart_len > MAX_LEN) ? MAX_LEN : bus.i_chart_len;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        emit    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    len_d   = len_in;
                end
            end
            ST_RUN: begin
                if (bus.i_start) begin
                    idx_d = '0;
                    len_d = len_in;
                end else if (idx_q >= len_q) begin
                    state_d = ST_DONE;
                end else if (!bus.i_pause && due) begin
                    emit  = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            len_q            <= '0;
            bus.o_note       <= '0;
            bus.o_note_valid <= 1'b0;
            bus.o_note_idx   <= '0;
            bus.o_gen_pitch  <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            len_q            <= len_d;
            bus.o_note       <= emit ? mask_mem[rd_idx] : '0;
            bus.o_note_valid <= emit;
            if (emit) begin
                bus.o_note_idx  <= idx_q;
                bus.o_gen_pitch <= pitch_mem[rd_idx];
            end
        end
    end

    assign bus.o_busy     = (state_q == ST_RUN);
    assign bus.o_game_end = (state_q == ST_DONE);
endmodule

// File: tb/tb_note_seq.sv
// Bench for note_seq: two instances (lead 0 and lead 300 ms) share one stimulus stream and are
// compared every cycle against a queue-based playback model of the chart.
module tb_note_seq;
    localparam int NT = 4;
    localparam int NC = 64;
    localparam int TW = 32;
    localparam int PW = 32;
    localparam int IW = 7;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] cur_time = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [IW-1:0] chart_len = '0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [TW-1:0] wr_time = '0;
    logic [NT-1:0] wr_mask = '0;
    logic [PW-1:0] wr_pitch = '0;

    always #10 clk = ~clk;

    note_seq_if #(.NUM_TRACKS(NT), .TIME_W(TW), .PITCH_W(PW), .IDX_W(IW)) bus0 ();
    note_seq_if #(.NUM_TRACKS(NT), .TIME_W(TW), .PITCH_W(PW), .IDX_W(IW)) bus1 ();

    assign bus0.i_cur_time = cur_time;  assign bus1.i_cur_time = cur_time;
    assign bus0.i_start = start;        assign bus1.i_start = start;
    assign bus0.i_pause = pause;        assign bus1.i_pause = pause;
    assign bus0.i_chart_len = chart_len; assign bus1.i_chart_len = chart_len;
    assign bus0.i_wr_en = wr_en;        assign bus1.i_wr_en = wr_en;
    assign bus0.i_wr_addr = wr_addr;    assign bus1.i_wr_addr = wr_addr;
    assign bus0.i_wr_time = wr_time;    assign bus1.i_wr_time = wr_time;
    assign bus0.i_wr_mask = wr_mask;    assign bus1.i_wr_mask = wr_mask;
    assign bus0.i_wr_pitch = wr_pitch;  assign bus1.i_wr_pitch = wr_pitch;

    note_seq #(.NUM_TRACKS(NT), .NOTE_COUNT(NC), .TIME_W(TW), .PITCH_W(PW), .LEAD_MS(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    note_seq #(.NUM_TRACKS(NT), .NOTE_COUNT(NC), .TIME_W(TW), .PITCH_W(PW), .LEAD_MS(300))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_pulse [2];

    // reference model: chart copy per instance plus a queue of notes still to be issued
    logic [TW-1:0] m_time  [2][NC];
    logic [NT-1:0] m_mask  [2][NC];
    logic [PW-1:0] m_pitch [2][NC];
    int            m_phase [2];
    int            pend0 [$];
    int            pend1 [$];
    logic [NT-1:0] e_note  [2];
    logic          e_valid [2];
    logic [IW-1:0] e_idx   [2];
    logic [PW-1:0] e_pitch [2];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lead_ms(int d);
        return (d == 0) ? 0 : 300;
    endfunction

    task automatic pend_fill(int d, int n);
        if (d == 0) begin
            pend0.delete();
            for (int i = 0; i < n; i++) pend0.push_back(i);
        end else begin
            pend1.delete();
            for (int i = 0; i < n; i++) pend1.push_back(i);
        end
    endtask

    function automatic int pend_size(int d);
        return (d == 0) ? pend0.size() : pend1.size();
    endfunction

    function automatic int pend_front(int d);
        return (d == 0) ? pend0[0] : pend1[0];
    endfunction

    task automatic pend_drop(int d);
        if (d == 0) void'(pend0.pop_front());
        else        void'(pend1.pop_front());
    endtask

    task automatic model_edge(int d);
        logic [33:0] lhs, rhs;
        int k;
        if (!rst_n) begin
            m_phase[d] = P_IDLE;
            pend_fill(d, 0);
            e_note[d] = '0; e_valid[d] = 1'b0; e_idx[d] = '0; e_pitch[d] = '0;
            return;
        end
        e_note[d]  = '0;
        e_valid[d] = 1'b0;
        if (m_phase[d] != P_RUN && wr_en && wr_addr < IW'(NC)) begin
            m_time[d][wr_addr[5:0]]  = wr_time;
            m_mask[d][wr_addr[5:0]]  = wr_mask;
            m_pitch[d][wr_addr[5:0]] = wr_pitch;
        end
        if (start) begin
            m_phase[d] = P_RUN;
            pend_fill(d, (chart_len > IW'(NC)) ? NC : int'(chart_len));
        end else if (m_phase[d] == P_RUN) begin
            if (pend_size(d) == 0) begin
                m_phase[d] = P_DONE;
            end else if (!pause) begin
                k   = pend_front(d);
                lhs = {2'b00, cur_time} + 34'(lead_ms(d));
                rhs = {2'b00, m_time[d][k]};
                if (lhs >= rhs) begin
                    pend_drop(d);
                    e_note[d]  = m_mask[d][k];
                    e_valid[d] = 1'b1;
                    e_idx[d]   = IW'(k);
                    e_pitch[d] = m_pitch[d][k];
                end
            end
        end
    endtask

    task automatic check_dut(int d, logic [NT-1:0] note, logic valid, logic [IW-1:0] idx,
                             logic [PW-1:0] pitch, logic busy, logic gend);
        chk($sformatf("d%0d_note", d),  64'(note),  64'(e_note[d]));
        chk($sformatf("d%0d_valid", d), 64'(valid), 64'(e_valid[d]));
        chk($sformatf("d%0d_idx", d),   64'(idx),   64'(e_idx[d]));
        chk($sformatf("d%0d_pitch", d), 64'(pitch), 64'(e_pitch[d]));
        chk($sformatf("d%0d_busy", d),  64'(busy),  64'(m_phase[d] == P_RUN));
        chk($sformatf("d%0d_end", d),   64'(gend),  64'(m_phase[d] == P_DONE));
        if (valid === 1'b1) n_pulse[d]++;
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        cyc++;
        check_dut(0, bus0.o_note, bus0.o_note_valid, bus0.o_note_idx, bus0.o_gen_pitch,
                  bus0.o_busy, bus0.o_game_end);
        check_dut(1, bus1.o_note, bus1.o_note_valid, bus1.o_note_idx, bus1.o_gen_pitch,
                  bus1.o_busy, bus1.o_game_end);
    endtask

    task automatic write_note(int addr, logic [TW-1:0] t, logic [NT-1:0] m, logic [PW-1:0] p);
        wr_en = 1'b1; wr_addr = IW'(addr); wr_time = t; wr_mask = m; wr_pitch = p;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(int len);
        chart_len = IW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ramp(int t0, int t1, int clk_per_ms, int p0, int p1);
        for (int t = t0; t <= t1; t++) begin
            cur_time = TW'(t);
            pause = (t >= p0) && (t < p1);
            repeat (clk_per_ms) tick();
        end
        pause = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [TW-1:0] t, base;
        do_reset();

        // three-note song, lanes 2/0/2; lead-300 instance fires at 700/1236/1772
        write_note(0, 1000, 4'b0100, 127551);
        write_note(1, 1536, 4'b0001, 107296);
        write_note(2, 2072, 4'b0100, 95556);
        cur_time = 600;
        n_pulse[0] = 0; n_pulse[1] = 0;
        pulse_start(3);
        ramp(600, 2100, 10, -1, -1);
        chk("a_count0", 64'(n_pulse[0]), 64'd3);
        chk("a_count1", 64'(n_pulse[1]), 64'd3);
        chk("a_end0", 64'(bus0.o_game_end), 64'd1);

        // replay from DONE with pause held across note 1
        cur_time = 990;
        n_pulse[0] = 0;
        pulse_start(3);
        ramp(990, 2100, 2, 1500, 1600);
        chk("b_count0", 64'(n_pulse[0]), 64'd3);

        // chord then two ties at t=500
        write_note(0, 500, 4'b1011, 11);
        write_note(1, 500, 4'b0100, 22);
        write_note(2, 500, 4'b1000, 33);
        cur_time = 0;
        pulse_start(3);
        repeat (4) tick();
        cur_time = 500;
        repeat (6) tick();

        // empty chart
        n_pulse[0] = 0;
        pulse_start(0);
        repeat (3) tick();
        chk("d_count0", 64'(n_pulse[0]), 64'd0);

        // reset mid-run, write during run, replay
        write_note(0, 100, 4'b0001, 5);
        write_note(1, 200, 4'b0010, 6);
        write_note(2, 300, 4'b0100, 7);
        cur_time = 0;
        pulse_start(3);
        cur_time = 150;
        repeat (3) tick();
        write_note(0, 5, 4'b1111, 32'h1234);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cur_time = 0;
        pulse_start(3);
        ramp(0, 400, 1, -1, -1);

        // full chart with oversized length, plus dropped out-of-range writes
        t = 10;
        for (int i = 0; i < NC; i++) begin
            t = t + TW'($urandom_range(0, 3));
            write_note(i, t, NT'($urandom), $urandom);
        end
        for (int i = 0; i < 4; i++)
            write_note($urandom_range(64, 127), 0, 4'b1111, 32'hDEAD);
        cur_time = 0;
        n_pulse[0] = 0; n_pulse[1] = 0;
        pulse_start(200);
        for (int i = 0; i < 300; i++) begin
            cur_time = TW'(i);
            pause = ($urandom_range(0, 4) == 0);
            tick();
        end
        pause = 1'b0;
        cur_time = 400;
        repeat (80) tick();
        chk("f_count0", 64'(n_pulse[0]), 64'd64);
        chk("f_count1", 64'(n_pulse[1]), 64'd64);
        chk("f_end0", 64'(bus0.o_game_end), 64'd1);

        // no wrap at the top of the time range
        write_note(0, 32'hFFFF_FFFF, 4'b1001, 99);
        cur_time = 32'hFFFF_FF00;
        pulse_start(1);
        repeat (3) tick();
        cur_time = 32'hFFFF_FFFF;
        repeat (3) tick();

        // randomized rounds, including decreasing entries and near-max times
        for (int r = 0; r < 6; r++) begin
            do_reset();
            base = (r == 5) ? 32'hFFFF_F000 : 32'd0;
            t = base + 32'd50;
            for (int i = 0; i < NC; i++) begin
                t = t + TW'($urandom_range(0, 40));
                write_note(i, (($urandom_range(0, 7) == 0) ? t - TW'($urandom_range(0, 30)) : t),
                           NT'($urandom), $urandom);
            end
            cur_time = base;
            pulse_start($urandom_range(0, 80));
            for (int c = 0; c < 1500; c++) begin
                pause = ($urandom_range(0, 4) == 0);
                start = ($urandom_range(0, 299) == 0);
                if (start) chart_len = IW'($urandom_range(0, 80));
                wr_en = ($urandom_range(0, 49) == 0);
                wr_addr = IW'($urandom_range(0, 127));
                wr_time = cur_time + TW'($urandom_range(0, 100));
                wr_mask = NT'($urandom);
                wr_pitch = $urandom;
                rst_n = ($urandom_range(0, 999) != 0);
                tick();
                start = 1'b0;
                wr_en = 1'b0;
                rst_n = 1'b1;
                cur_time = cur_time + TW'($urandom_range(0, 3));
            end
            pause = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
